// File: rtl/tracker_pkg.sv
// Shared types and helpers for the centroid tracker: FSM states, per-axis
// update operations and a saturating clamp to the frame bounds.
package tracker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    TRACK,
    COAST
  } state_t;

  // Update applied to one axis estimate on a frame edge
  typedef enum logic [2:0] {
    OP_HOLD,     // keep est and velocity
    OP_LOAD,     // est = meas, velocity = 0
    OP_EMA,      // smoothed step toward meas, velocity = est' - est
    OP_PREDICT,  // est = est + velocity
    OP_STOP      // est held, velocity = 0
  } axis_op_t;

  localparam int CLAMP_W = 16;

  function automatic logic [CLAMP_W-1:0] clamp_pos(
    input logic signed [CLAMP_W-1:0] value,
    input logic        [CLAMP_W-1:0] bound
  );
    logic [CLAMP_W-1:0] result;
    if (value < 0) begin
      result = '0;
    end else if ($unsigned(value) > bound) begin
      result = bound;
    end else begin
      result = $unsigned(value);
    end
    return result;
  endfunction

endpackage

// File: rtl/ema_axis.sv
// One tracking axis: holds the position estimate and velocity, and provides
// the jump gate, shift-based EMA, velocity and clamped prediction.
module ema_axis
  import tracker_pkg::*;
#(
  parameter int W           = 11,
  parameter int BOUND       = 1023,
  parameter int ALPHA_SHIFT = 2,
  parameter int JUMP_THRESH = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  axis_op_t            op,
  input  logic [W-1:0]        meas,
  output logic [W-1:0]        est,
  output logic signed [W:0]   vel,
  output logic                in_gate
);

  logic [W-1:0]        est_reg;
  logic signed [W:0]   vel_reg;
  logic signed [W:0]   diff;
  logic signed [W:0]   step;
  logic [W:0]          mag;
  logic signed [W+1:0] ema_raw;
  logic signed [W+1:0] pred_raw;
  logic [W-1:0]        load_pos;
  logic [W-1:0]        ema_pos;
  logic [W-1:0]        pred_pos;
  logic signed [W:0]   ema_vel;

  assign diff    = $signed({1'b0, meas}) - $signed({1'b0, est_reg});
  assign mag     = diff[W] ? $unsigned(-diff) : $unsigned(diff);
  assign in_gate = 32'(mag) <= JUMP_THRESH;

  // Arithmetic shift rounds toward -inf, so downward steps are never lost
  assign step     = diff >>> ALPHA_SHIFT;
  assign ema_raw  = $signed({2'b00, est_reg}) + step;
  assign pred_raw = $signed({2'b00, est_reg}) + vel_reg;

  assign load_pos = W'(clamp_pos(CLAMP_W'($signed({1'b0, meas})), CLAMP_W'(BOUND)));
  assign ema_pos  = W'(clamp_pos(CLAMP_W'(ema_raw), CLAMP_W'(BOUND)));
  assign pred_pos = W'(clamp_pos(CLAMP_W'(pred_raw), CLAMP_W'(BOUND)));
  assign ema_vel  = $signed({1'b0, ema_pos}) - $signed({1'b0, est_reg});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      est_reg <= '0;
      vel_reg <= '0;
    end else begin
      case (op)
        OP_LOAD: begin
          est_reg <= load_pos;
          vel_reg <= '0;
        end
        OP_EMA: begin
          est_reg <= ema_pos;
          vel_reg <= ema_vel;
        end
        OP_PREDICT: est_reg <= pred_pos;
        OP_STOP:    vel_reg <= '0;
        default: ;
      endcase
    end
  end

  assign est = est_reg;
  assign vel = vel_reg;

endmodule

// File: rtl/centroid_tracker.sv
// Frame-rate centroid tracker: latches one measurement per frame, runs the
// acquire/track/coast FSM on frame_done and publishes results one cycle later.
module centroid_tracker
  import tracker_pkg::*;
#(
  parameter int WIDTH       = 1024,
  parameter int HEIGHT      = 768,
  parameter int ALPHA_SHIFT = 2,
  parameter int LOCK_FRAMES = 3,
  parameter int LOST_FRAMES = 8,
  parameter int JUMP_THRESH = 128
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [10:0]        x_in,
  input  logic [9:0]         y_in,
  input  logic               valid_in,
  input  logic               frame_done_in,
  output logic [10:0]        x_out,
  output logic [9:0]         y_out,
  output logic signed [11:0] dx_out,
  output logic signed [10:0] dy_out,
  output logic               locked_out,
  output logic               lost_out,
  output logic               valid_out
);

  localparam int HW = $clog2(LOCK_FRAMES + 1);
  localparam int MW = $clog2(LOST_FRAMES + 1);

  state_t              state_reg, state_next;
  logic [HW-1:0]       hit_cnt_reg, hit_cnt_next;
  logic [MW-1:0]       miss_cnt_reg, miss_cnt_next;
  logic                hit_pend_reg;
  logic [10:0]         meas_x_reg;
  logic [9:0]          meas_y_reg;
  logic                eval_reg;
  logic                lost_evt_reg, lost_next;
  axis_op_t            axis_op;

  logic                frame_hit;
  logic                gate_ok;
  logic [10:0]         meas_x;
  logic [9:0]          meas_y;
  logic                gate_x, gate_y;
  logic [10:0]         est_x;
  logic [9:0]          est_y;
  logic signed [11:0]  vel_x;
  logic signed [10:0]  vel_y;

  // A measurement arriving with frame_done belongs to the closing frame
  assign frame_hit = hit_pend_reg | valid_in;
  assign meas_x    = valid_in ? x_in : meas_x_reg;
  assign meas_y    = valid_in ? y_in : meas_y_reg;
  assign gate_ok   = frame_hit & gate_x & gate_y;

  ema_axis #(
    .W(11), .BOUND(WIDTH - 1), .ALPHA_SHIFT(ALPHA_SHIFT), .JUMP_THRESH(JUMP_THRESH)
  ) u_axis_x (
    .clk(clk_in), .rst_n(rst_n_in), .op(axis_op), .meas(meas_x),
    .est(est_x), .vel(vel_x), .in_gate(gate_x)
  );

  ema_axis #(
    .W(10), .BOUND(HEIGHT - 1), .ALPHA_SHIFT(ALPHA_SHIFT), .JUMP_THRESH(JUMP_THRESH)
  ) u_axis_y (
    .clk(clk_in), .rst_n(rst_n_in), .op(axis_op), .meas(meas_y),
    .est(est_y), .vel(vel_y), .in_gate(gate_y)
  );

  always_comb begin
    state_next    = state_reg;
    hit_cnt_next  = hit_cnt_reg;
    miss_cnt_next = miss_cnt_reg;
    axis_op       = OP_HOLD;
    lost_next     = 1'b0;
    if (frame_done_in) begin
      case (state_reg)
        IDLE: begin
          if (frame_hit) begin
            axis_op       = OP_LOAD;
            hit_cnt_next  = HW'(1);
            miss_cnt_next = '0;
            state_next    = (LOCK_FRAMES == 1) ? TRACK : ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (gate_ok) begin
            axis_op = OP_EMA;
            if (int'(hit_cnt_reg) + 1 >= LOCK_FRAMES) begin
              hit_cnt_next = HW'(LOCK_FRAMES);
              state_next   = TRACK;
            end else begin
              hit_cnt_next = hit_cnt_reg + HW'(1);
            end
          end else if (frame_hit) begin
            axis_op      = OP_LOAD;
            hit_cnt_next = HW'(1);
          end else begin
            axis_op      = OP_STOP;
            hit_cnt_next = '0;
            state_next   = IDLE;
          end
        end
        TRACK: begin
          if (gate_ok) begin
            axis_op = OP_EMA;
          end else if (LOST_FRAMES == 1) begin
            axis_op       = OP_STOP;
            lost_next     = 1'b1;
            hit_cnt_next  = '0;
            miss_cnt_next = '0;
            state_next    = IDLE;
          end else begin
            axis_op       = OP_PREDICT;
            miss_cnt_next = MW'(1);
            state_next    = COAST;
          end
        end
        COAST: begin
          if (gate_ok) begin
            axis_op       = OP_EMA;
            miss_cnt_next = '0;
            state_next    = TRACK;
          end else if (int'(miss_cnt_reg) + 1 >= LOST_FRAMES) begin
            axis_op       = OP_STOP;
            lost_next     = 1'b1;
            hit_cnt_next  = '0;
            miss_cnt_next = '0;
            state_next    = IDLE;
          end else begin
            axis_op       = OP_PREDICT;
            miss_cnt_next = miss_cnt_reg + MW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_reg    <= IDLE;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
      hit_pend_reg <= 1'b0;
      meas_x_reg   <= '0;
      meas_y_reg   <= '0;
      eval_reg     <= 1'b0;
      lost_evt_reg <= 1'b0;
      x_out        <= '0;
      y_out        <= '0;
      dx_out       <= '0;
      dy_out       <= '0;
      locked_out   <= 1'b0;
      lost_out     <= 1'b0;
      valid_out    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hit_cnt_reg  <= hit_cnt_next;
      miss_cnt_reg <= miss_cnt_next;
      if (frame_done_in) begin
        hit_pend_reg <= 1'b0;
      end else if (valid_in) begin
        hit_pend_reg <= 1'b1;
      end
      if (valid_in) begin
        meas_x_reg <= x_in;
        meas_y_reg <= y_in;
      end
      eval_reg     <= frame_done_in;
      lost_evt_reg <= lost_next;
      // Publish the estimate one cycle after the frame edge that updated it
      valid_out    <= eval_reg;
      lost_out     <= eval_reg & lost_evt_reg;
      if (eval_reg) begin
        x_out      <= est_x;
        y_out      <= est_y;
        dx_out     <= vel_x;
        dy_out     <= vel_y;
        locked_out <= (state_reg == TRACK) || (state_reg == COAST);
      end
    end
  end

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed bench for centroid_tracker: a table of per-frame vectors with
// hand-computed results, plus short sequences for reset and strobe corners.
module tb_centroid_tracker;

  typedef struct {
    bit rst;
    bit hit;
    bit co;
    int x;
    int y;
    int ex;
    int ey;
    int edx;
    int edy;
    bit elock;
    bit elost;
  } frame_vec_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [10:0]        x_in = '0;
  logic [9:0]         y_in = '0;
  logic               valid_in = 1'b0;
  logic               frame_done_in = 1'b0;
  logic [10:0]        x_out;
  logic [9:0]         y_out;
  logic signed [11:0] dx_out;
  logic signed [10:0] dy_out;
  logic               locked_out;
  logic               lost_out;
  logic               valid_out;

  int checks = 0;
  int errors = 0;
  frame_vec_t vq[$];

  centroid_tracker dut (
    .clk_in(clk), .rst_n_in(rst_n), .x_in(x_in), .y_in(y_in),
    .valid_in(valid_in), .frame_done_in(frame_done_in),
    .x_out(x_out), .y_out(y_out), .dx_out(dx_out), .dy_out(dy_out),
    .locked_out(locked_out), .lost_out(lost_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic add(input bit r, input bit h, input bit c, input int x, input int y,
                     input int ex, input int ey, input int edx, input int edy,
                     input bit lk, input bit ls);
    vq.push_back('{r, h, c, x, y, ex, ey, edx, edy, lk, ls});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_outputs(input string tag, input int ex, input int ey, input int edx,
                               input int edy, input bit lk, input bit ls);
    check({tag, ".x"}, int'(x_out), ex);
    check({tag, ".y"}, int'(y_out), ey);
    check({tag, ".dx"}, int'(dx_out), edx);
    check({tag, ".dy"}, int'(dy_out), edy);
    check({tag, ".locked"}, int'(locked_out), int'(lk));
    check({tag, ".lost"}, int'(lost_out), int'(ls));
  endtask

  // Drive one frame and wait (bounded) for its valid_out pulse
  task automatic run_frame(input bit hit, input bit co, input int x, input int y, output bit seen);
    @(negedge clk);
    if (hit && !co) begin
      valid_in = 1'b1;
      x_in = 11'(x);
      y_in = 10'(y);
      @(negedge clk);
      valid_in = 1'b0;
    end
    frame_done_in = 1'b1;
    if (hit && co) begin
      valid_in = 1'b1;
      x_in = 11'(x);
      y_in = 10'(y);
    end
    @(negedge clk);
    frame_done_in = 1'b0;
    valid_in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (valid_out) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("valid_out_seen", int'(seen), 1);
  endtask

  initial begin
    bit seen;
    int pulses;

    // Lock, EMA, coast to loss
    add(0, 1, 0, 512, 384, 512, 384, 0, 0, 0, 0);
    add(0, 1, 0, 512, 384, 512, 384, 0, 0, 0, 0);
    add(0, 1, 0, 512, 384, 512, 384, 0, 0, 1, 0);
    add(0, 1, 0, 528, 380, 516, 383, 4, -1, 1, 0);
    for (int k = 1; k <= 7; k++) add(0, 0, 0, 0, 0, 516 + 4 * k, 383 - k, 4, -1, 1, 0);
    add(0, 0, 0, 0, 0, 544, 376, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 544, 376, 0, 0, 0, 0);
    // Outlier gate and its exact boundary
    add(0, 1, 0, 512, 384, 512, 384, 0, 0, 0, 0);
    add(0, 1, 0, 512, 384, 512, 384, 0, 0, 0, 0);
    add(0, 1, 0, 512, 384, 512, 384, 0, 0, 1, 0);
    add(0, 1, 0, 900, 384, 512, 384, 0, 0, 1, 0);
    add(0, 1, 0, 640, 384, 544, 384, 32, 0, 1, 0);
    add(0, 1, 0, 673, 384, 576, 384, 32, 0, 1, 0);
    // Clamp at right edge, coincident valid_in/frame_done
    add(1, 1, 1, 1006, 200, 1006, 200, 0, 0, 0, 0);
    add(0, 1, 0, 1006, 200, 1006, 200, 0, 0, 0, 0);
    add(0, 1, 0, 1006, 200, 1006, 200, 0, 0, 1, 0);
    add(0, 1, 1, 1022, 200, 1010, 200, 4, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1014, 200, 4, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1018, 200, 4, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1022, 200, 4, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1023, 200, 4, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1023, 200, 4, 0, 1, 0);
    // Acquire miss and acquire out-of-gate reload
    add(1, 1, 0, 100, 50, 100, 50, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 100, 50, 0, 0, 0, 0);
    add(0, 1, 0, 100, 50, 100, 50, 0, 0, 0, 0);
    add(0, 1, 0, 400, 50, 400, 50, 0, 0, 0, 0);
    add(0, 1, 0, 400, 50, 400, 50, 0, 0, 0, 0);
    add(0, 1, 0, 400, 50, 400, 50, 0, 0, 1, 0);

    repeat (3) @(negedge clk);
    check_outputs("reset", 0, 0, 0, 0, 0, 0);
    check("reset.valid", int'(valid_out), 0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      run_frame(vq[i].hit, vq[i].co, vq[i].x, vq[i].y, seen);
      $display("frame %0d hit=%0d co=%0d meas=(%0d,%0d) -> pos=(%0d,%0d) d=(%0d,%0d) locked=%0d lost=%0d",
               i, vq[i].hit, vq[i].co, vq[i].x, vq[i].y, x_out, y_out, dx_out, dy_out,
               locked_out, lost_out);
      check_outputs($sformatf("vec%0d", i), vq[i].ex, vq[i].ey, vq[i].edx, vq[i].edy,
                    vq[i].elock, vq[i].elost);
    end

    // Reset while coasting
    run_frame(0, 0, 0, 0, seen);
    $display("coast before reset -> pos=(%0d,%0d) locked=%0d", x_out, y_out, locked_out);
    check_outputs("pre_reset", 400, 50, 0, 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs("mid_reset", 0, 0, 0, 0, 0, 0);
    check("mid_reset.valid", int'(valid_out), 0);
    rst_n = 1'b1;
    run_frame(0, 0, 0, 0, seen);
    $display("miss after reset -> pos=(%0d,%0d) locked=%0d valid=%0d", x_out, y_out, locked_out, valid_out);
    check_outputs("post_reset", 0, 0, 0, 0, 0, 0);

    // Two measurements in one frame: the later one wins
    @(negedge clk);
    valid_in = 1'b1; x_in = 11'd300; y_in = 10'd100;
    @(negedge clk);
    x_in = 11'd600; y_in = 10'd200;
    @(negedge clk);
    valid_in = 1'b0;
    run_frame(0, 0, 0, 0, seen);
    $display("last-wins frame -> pos=(%0d,%0d)", x_out, y_out);
    check_outputs("last_wins", 600, 200, 0, 0, 0, 0);

    // Back-to-back frame strobes each produce a pulse
    @(negedge clk);
    frame_done_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    frame_done_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (valid_out) pulses++;
      @(negedge clk);
    end
    $display("back-to-back frames -> valid_out pulses=%0d locked=%0d", pulses, locked_out);
    check("b2b.pulses", pulses, 2);
    check("b2b.locked", int'(locked_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/centroid_tracker.md
# centroid_tracker

Frame-rate tracker directly downstream of `center_of_mass`. It consumes one centroid per frame (or none when the frame had no pixels), rejects outliers with a jump gate, smooths position with a shift-based EMA, and estimates per-frame velocity. It coasts through short dropouts by prediction and declares the target lost after a run of misses. Its outputs drive the overlay and steering logic once per frame.

## Interface
- `WIDTH`, 1024: frame width in pixels; x is clamped to [0, WIDTH-1].
- `HEIGHT`, 768: frame height in pixels; y is clamped to [0, HEIGHT-1].
- `ALPHA_SHIFT`, 2: EMA weight is 1/2^ALPHA_SHIFT.
- `LOCK_FRAMES`, 3: consecutive gated hits required to lock (≥1).
- `LOST_FRAMES`, 8: consecutive misses while locked before the target is declared lost (≥1).
- `JUMP_THRESH`, 128: maximum |meas−est| per axis accepted as the same target.

Ports:
- `clk_in` in 1: the single clock.
- `rst_n_in` in 1: synchronous, active-low reset.
- `x_in` in 11: centroid x from `center_of_mass`.
- `y_in` in 10: centroid y from `center_of_mass`.
- `valid_in` in 1: single-cycle pulse; x_in/y_in are valid in that cycle.
- `frame_done_in` in 1: single-cycle pulse once per frame; this is the same strobe that drives `tabulate_in` upstream.
- `x_out` out 11: tracked x.
- `y_out` out 10: tracked y.
- `dx_out` out 12 signed: x velocity in pixels per frame.
- `dy_out` out 11 signed: y velocity in pixels per frame.
- `locked_out` out 1: high in TRACK or COAST.
- `lost_out` out 1: one-cycle pulse on the COAST→IDLE transition.
- `valid_out` out 1: one-cycle pulse per frame; all other outputs are updated in that cycle.

## Operation
- **Measurement latch:** on `valid_in`, latch the measurement and set `hit_pend`. If a second `valid_in` arrives in the same frame, the last one wins.
- **Frame evaluation:** on `frame_done_in`, evaluate the frame as a hit if `hit_pend` is set, otherwise as a miss, then clear `hit_pend`.
  - If `valid_in` and `frame_done_in` are high in the same cycle, that measurement counts for the frame that is closing.
- **Gate:** a hit is in-gate when |meas−est| ≤ JUMP_THRESH on both axes.
- **EMA:** est' = est + ((meas−est) >>> ALPHA_SHIFT). Compute it as a signed diff of axis-width+1 bits with an arithmetic shift, which rounds toward −∞.
- **Velocity:** d = est' − est_prev on every EMA update.
- **Predict:** est' = clamp(est + d).
- **Clamping:** all position results are clamped to the frame bounds.
- **State machine** (`hit_cnt`, `miss_cnt` are saturating counters):
  - **IDLE:**
    - Hit: est = meas, d = 0, `hit_cnt` = 1. Go to ACQUIRE, or directly to TRACK if LOCK_FRAMES = 1.
    - Miss: stay in IDLE.
  - **ACQUIRE:**
    - In-gate hit: EMA update and `hit_cnt`++. Go to TRACK when `hit_cnt` reaches LOCK_FRAMES.
    - Out-of-gate hit: reload est = meas, `hit_cnt` = 1.
    - Miss: go to IDLE, d = 0.
  - **TRACK:**
    - In-gate hit: EMA update plus velocity update.
    - Miss or out-of-gate hit: predict, `miss_cnt` = 1, go to COAST (or IDLE with `lost_out` if LOST_FRAMES = 1).
  - **COAST:**
    - In-gate hit: EMA update plus velocity update, `miss_cnt` = 0, go to TRACK.
    - Miss or out-of-gate hit: predict and `miss_cnt`++. When `miss_cnt` reaches LOST_FRAMES: go to IDLE, pulse `lost_out`, d = 0, est held.
- **Reset:** an active `rst_n_in` at any time forces IDLE and clears `hit_pend`, all counters, est and d.

## Timing
- **Reset values:** `x_out`, `y_out`, `dx_out`, `dy_out` = 0; `locked_out`, `lost_out`, `valid_out` = 0.
- **Latency:** the state and estimate update completes on the edge that samples `frame_done_in`. `valid_out`, `lost_out` and the new outputs appear on the following edge (1-cycle latency).
- **Frame pulse:** `valid_out` pulses once per `frame_done_in`, including miss frames and IDLE frames. Outputs hold their values between pulses.
- **Sampling:** `valid_in` is sampled on every cycle, including the `valid_out` cycle. There is no back-pressure.
- **Pulse spacing:** back-to-back `frame_done_in` pulses (1 cycle apart) must each produce a `valid_out`.

## Structure
- **Shared package:** `tracker_pkg` holds the state enum (IDLE, ACQUIRE, TRACK, COAST) and a parameterised clamp function.
- **Sub-module:** `ema_axis`, parameterised by axis width and bound, instantiated once per axis. It contains the gate compare, EMA, velocity and predict/clamp logic, and reports `in_gate`. The top level owns the FSM, counters and measurement latch.

## Test plan
Defaults apply unless stated.
- **Lock:** hits at (512,384) for 3 frames → `locked_out` = 0, 0, 1 on successive `valid_out` pulses, and `x_out`/`y_out` = 512/384 on all three.
- **EMA and velocity:** locked at (512,384), hit at (528,380) → `x_out` = 516, `y_out` = 383, `dx_out` = +4, `dy_out` = −1.
- **Coast and loss:** locked at x = 516 with dx = +4, then 8 miss frames → `x_out` = 520, 524, …; `locked_out` = 1 for the first 7 frames; on the 8th, `lost_out` pulses, `locked_out` = 0 and `dx_out` = 0.
- **Outlier gate:** locked at x = 512 with dx = 0, hit at 900 → treated as a miss: COAST, `x_out` = 512, `locked_out` = 1.
- **Clamp and simultaneity:** coasting at x = 1022 with dx = +4 → `x_out` = 1023. Separately, `valid_in` coincident with `frame_done_in` counts as a hit for that frame.
- **Reset mid-COAST:** reset → all outputs 0 next cycle; the next miss frame gives `valid_out` = 1 with `locked_out` = 0 and `x_out` = 0.
